// File: rtl/inst_bus_stim_pkg.sv
// Shared types and defaults for the instruction-bus stimulus responder.
package inst_bus_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_ADDR   = 1'b0,
    MODE_STREAM = 1'b1
  } mode_e;

  localparam int unsigned    FILL_W        = 18;
  localparam logic [FILL_W-1:0] FILL_INST_DEF = 18'h00000;

endpackage

// File: rtl/inst_bus_stim_if.sv
// Gumnut-style instruction fetch bus: core is master, responder is slave.
interface inst_bus_stim_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 18
) ();

  logic              cyc_i;
  logic              stb_i;
  logic [ADDR_W-1:0] adr_i;
  logic              ack_o;
  logic [DATA_W-1:0] dat_o;

  modport master (
    output cyc_i, stb_i, adr_i,
    input  ack_o, dat_o
  );

  modport slave (
    input  cyc_i, stb_i, adr_i,
    output ack_o, dat_o
  );

endinterface

// File: rtl/inst_script_ram.sv
// Script storage: one synchronous write port, one asynchronous read port.
module inst_script_ram #(
  parameter int unsigned PTR_W  = 6,
  parameter int unsigned DATA_W = 18
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  wadr_i,
  input  logic [DATA_W-1:0] wdat_i,
  input  logic [PTR_W-1:0]  radr_i,
  output logic [DATA_W-1:0] rdat_c_o
);

  localparam int unsigned DEPTH = 2 ** PTR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; the bench or loader fills them.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wadr_i] <= wdat_i;
    end
  end

  assign rdat_c_o = mem_q[radr_i];

endmodule

// File: rtl/inst_bus_stim.sv
// Instruction-bus responder: serves a loadable script as a ROM (addressed)
// or as an in-order stream, with programmable ack latency and fetch counting.
module inst_bus_stim
  import inst_bus_stim_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 12,
  parameter int unsigned       DATA_W    = 18,
  parameter int unsigned       DEPTH     = 64,
  parameter int unsigned       WAIT_W    = 2,
  parameter logic [DATA_W-1:0] FILL_INST = DATA_W'(FILL_INST_DEF),
  parameter int unsigned       CNT_W     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  inst_bus_stim_if.slave            bus,
  input  logic                      mode_i,
  input  logic [WAIT_W-1:0]         wait_i,
  input  logic [$clog2(DEPTH):0]    stream_len_i,
  input  logic                      start_i,
  input  logic                      ld_we_i,
  input  logic [$clog2(DEPTH)-1:0]  ld_adr_i,
  input  logic [DATA_W-1:0]         ld_dat_i,
  output logic [CNT_W-1:0]          fetch_cnt_o,
  output logic                      done_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LEN_W = PTR_W + 1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [LEN_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              ack_q;

  logic              req_c, enter_ack_c, stream_c, adr_ok_c, ptr_ok_c;
  logic [PTR_W-1:0]  radr_c;
  logic [DATA_W-1:0] rdat_c;

  assign req_c    = bus.cyc_i & bus.stb_i;
  assign stream_c = (mode_e'(mode_i) == MODE_STREAM);
  assign adr_ok_c = ((bus.adr_i >> PTR_W) == '0);
  assign ptr_ok_c = (ptr_q < stream_len_i);
  assign radr_c   = stream_c ? ptr_q[PTR_W-1:0] : bus.adr_i[PTR_W-1:0];

  inst_script_ram #(
    .PTR_W  (PTR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i    (clk_i),
    .we_i     (ld_we_i),
    .wadr_i   (ld_adr_i),
    .wdat_i   (ld_dat_i),
    .radr_i   (radr_c),
    .rdat_c_o (rdat_c)
  );

  // Handshake FSM; wait_i is sampled only when leaving IDLE.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    enter_ack_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_c) begin
          if (wait_i == '0) begin
            state_d     = ACK;
            enter_ack_c = 1'b1;
          end else begin
            state_d = WAIT;
            wcnt_d  = wait_i;
          end
        end
      end
      WAIT: begin
        if (!req_c) begin
          state_d = IDLE;
        end else if (wcnt_q == WAIT_W'(1)) begin
          state_d     = ACK;
          enter_ack_c = 1'b1;
        end else begin
          wcnt_d = wcnt_q - WAIT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture uses the pre-write RAM word and pre-clear pointer; start wins.
  always_comb begin
    dat_d = dat_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (enter_ack_c) begin
      if (stream_c) begin
        dat_d = ptr_ok_c ? rdat_c : FILL_INST;
        if (ptr_ok_c) begin
          ptr_d = ptr_q + LEN_W'(1);
        end
      end else begin
        dat_d = adr_ok_c ? rdat_c : FILL_INST;
      end
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (start_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      ack_q   <= (state_d == ACK);
    end
  end

  assign bus.ack_o   = ack_q;
  assign bus.dat_o   = dat_q;
  assign fetch_cnt_o = cnt_q;
  assign done_o      = stream_c && (ptr_q >= stream_len_i);

endmodule

// File: tb/tb_inst_bus_stim.sv
// Bench for inst_bus_stim: directed scenarios plus randomized fetches checked
// against a script/pointer/counter model kept here.
module tb_inst_bus_stim;
  import inst_bus_stim_pkg::*;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 18;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned WAIT_W = 2;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LEN_W  = PTR_W + 1;
  localparam logic [DATA_W-1:0] FILL = 18'h00000;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              mode;
  logic [WAIT_W-1:0] wait_v;
  logic [LEN_W-1:0]  slen;
  logic              start;
  logic              ld_we;
  logic [PTR_W-1:0]  ld_adr;
  logic [DATA_W-1:0] ld_dat;
  logic [CNT_W-1:0]  fcnt;
  logic              done;

  inst_bus_stim_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  inst_bus_stim #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .WAIT_W(WAIT_W), .FILL_INST(FILL), .CNT_W(CNT_W)
  ) u_dut (
    .clk_i(clk), .rst_i(rst_n), .bus(bus), .mode_i(mode), .wait_i(wait_v),
    .stream_len_i(slen), .start_i(start), .ld_we_i(ld_we), .ld_adr_i(ld_adr),
    .ld_dat_i(ld_dat), .fetch_cnt_o(fcnt), .done_o(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] m_mem [DEPTH];
  int m_ptr = 0;
  int m_cnt = 0;

  // Reference: what one completed fetch returns, advancing pointer and count.
  function automatic logic [DATA_W-1:0] model_fetch(input logic [ADDR_W-1:0] adr);
    logic [DATA_W-1:0] w;
    if (mode) begin
      if (m_ptr < int'(slen)) begin
        w = m_mem[m_ptr];
        m_ptr++;
      end else w = FILL;
    end else begin
      if (int'(adr) < int'(DEPTH)) w = m_mem[int'(adr)];
      else w = FILL;
    end
    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    return w;
  endfunction

  function automatic logic exp_done();
    return mode && (m_ptr >= int'(slen));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [DATA_W-1:0] d);
    ld_we = 1'b1; ld_adr = PTR_W'(idx); ld_dat = d;
    tick();
    ld_we = 1'b0;
    m_mem[idx] = d;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_ptr = 0; m_cnt = 0;
  endtask

  task automatic req_on(input logic [ADDR_W-1:0] adr, input int w);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = adr; wait_v = WAIT_W'(w);
  endtask

  task automatic req_off();
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] adr, input int w, input string name);
    logic [DATA_W-1:0] exp;
    int n;
    bit got;
    exp = model_fetch(adr);
    req_on(adr, w);
    n = 0; got = 0;
    while (!got && n < 12) begin
      tick(); n++; got = bus.ack_o;
    end
    req_off();
    checks++;
    if (!got || n != w + 1) begin
      errors++; $display("FAIL %s latency: got %0d cycles ack=%0b, expected %0d", name, n, got, w + 1);
    end
    checks++;
    if (bus.dat_o !== exp) begin
      errors++; $display("FAIL %s dat: got %h expected %h", name, bus.dat_o, exp);
    end
    checks++;
    if (fcnt !== CNT_W'(m_cnt)) begin
      errors++; $display("FAIL %s cnt: got %0d expected %0d", name, fcnt, m_cnt);
    end
    checks++;
    if (done !== exp_done()) begin
      errors++; $display("FAIL %s done: got %b expected %b", name, done, exp_done());
    end
    tick();
    checks++;
    if (bus.ack_o !== 1'b0) begin
      errors++; $display("FAIL %s ack_width: got %b expected 0", name, bus.ack_o);
    end
  endtask

  task automatic test_reset();
    mode = 1'b1; slen = '0; wait_v = '0; start = 1'b0; ld_we = 1'b0;
    ld_adr = '0; ld_dat = '0; bus.adr_i = '0; req_off();
    rst_n = 1'b0;
    #12;
    checks++; if (bus.ack_o !== 1'b0) begin errors++; $display("FAIL reset ack: got %b expected 0", bus.ack_o); end
    checks++; if (bus.dat_o !== '0) begin errors++; $display("FAIL reset dat: got %h expected 0", bus.dat_o); end
    checks++; if (fcnt !== '0) begin errors++; $display("FAIL reset cnt: got %0d expected 0", fcnt); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL reset done_len0: got %b expected 1", done); end
    slen = LEN_W'(3); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done_len3: got %b expected 0", done); end
    mode = 1'b0; slen = '0; #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done_addr: got %b expected 0", done); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    for (int i = 0; i < int'(DEPTH); i++) load(i, DATA_W'($urandom));
    load(5, 18'h0080A);
  endtask

  task automatic test_addressed();
    mode = 1'b0;
    fetch(12'h005, 0, "addr_w0");
    fetch(12'h0FF, 3, "addr_oob_w3");
    fetch(12'h03F, 1, "addr_last");
    fetch(12'h040, 2, "addr_first_oob");
    fetch(12'h000, 0, "addr_zero");
  endtask

  task automatic test_abort();
    bit seen;
    mode = 1'b0;
    req_on(12'h005, 3);
    tick(); tick();
    bus.stb_i = 1'b0;
    seen = 0;
    repeat (6) begin tick(); if (bus.ack_o) seen = 1; end
    req_off();
    checks++; if (seen) begin errors++; $display("FAIL abort ack: got ack expected none"); end
    checks++; if (fcnt !== CNT_W'(m_cnt)) begin errors++; $display("FAIL abort cnt: got %0d expected %0d", fcnt, m_cnt); end
    fetch(12'h005, 2, "after_abort");
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] exp;
    int w, n;
    bit got;
    mode = 1'b1; slen = LEN_W'(3);
    do_start();
    for (int i = 0; i < 3; i++) load(i, DATA_W'($urandom));
    w = $urandom_range(0, 3);
    req_on(12'h000, w);
    for (int i = 0; i < 6; i++) begin
      n = 0; got = 0;
      while (!got && n < 12) begin
        bus.adr_i = ADDR_W'($urandom);
        tick(); n++; got = bus.ack_o;
      end
      exp = model_fetch('0);
      checks++;
      if (!got || n != ((i == 0) ? w + 1 : w + 2)) begin
        errors++; $display("FAIL stream%0d spacing: got %0d expected %0d", i, n, (i == 0) ? w + 1 : w + 2);
      end
      checks++;
      if (bus.dat_o !== exp) begin errors++; $display("FAIL stream%0d dat: got %h expected %h", i, bus.dat_o, exp); end
      checks++;
      if (done !== exp_done()) begin errors++; $display("FAIL stream%0d done: got %b expected %b", i, done, exp_done()); end
    end
    req_off();
    tick();
    checks++; if (fcnt !== CNT_W'(m_cnt)) begin errors++; $display("FAIL stream cnt: got %0d expected %0d", fcnt, m_cnt); end
  endtask

  task automatic test_start_coincident();
    logic [DATA_W-1:0] exp;
    int w;
    do_start();
    fetch(12'h000, $urandom_range(0, 3), "stream_A");
    w = $urandom_range(0, 3);
    exp = m_mem[m_ptr];
    req_on(12'h000, w);
    repeat (w) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_ptr = 0; m_cnt = 0;
    checks++; if (bus.ack_o !== 1'b1) begin errors++; $display("FAIL start_coinc ack: got %b expected 1", bus.ack_o); end
    checks++; if (bus.dat_o !== exp) begin errors++; $display("FAIL start_coinc dat: got %h expected %h", bus.dat_o, exp); end
    checks++; if (fcnt !== '0) begin errors++; $display("FAIL start_coinc cnt: got %0d expected 0", fcnt); end
    req_off();
    tick();
    fetch(12'h000, 0, "after_start_A");
  endtask

  task automatic test_rbw();
    logic [DATA_W-1:0] exp, newd;
    int w, idx;
    idx  = m_ptr;
    newd = m_mem[idx] ^ DATA_W'($urandom_range(1, (1 << DATA_W) - 1));
    w = $urandom_range(0, 3);
    req_on(12'h000, w);
    repeat (w) tick();
    ld_we = 1'b1; ld_adr = PTR_W'(idx); ld_dat = newd;
    tick();
    ld_we = 1'b0;
    exp = model_fetch('0);
    m_mem[idx] = newd;
    checks++; if (bus.dat_o !== exp) begin errors++; $display("FAIL rbw old_word: got %h expected %h", bus.dat_o, exp); end
    req_off();
    tick();
    do_start();
    fetch(12'h000, 1, "rbw_A");
    fetch(12'h000, 0, "rbw_new_word");
  endtask

  task automatic test_reset_mid();
    mode = 1'b0;
    req_on(12'h005, 3);
    tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    m_ptr = 0; m_cnt = 0;
    checks++; if (bus.ack_o !== 1'b0) begin errors++; $display("FAIL rst_wait ack: got %b expected 0", bus.ack_o); end
    checks++; if (fcnt !== '0) begin errors++; $display("FAIL rst_wait cnt: got %0d expected 0", fcnt); end
    req_off();
    @(negedge clk); rst_n = 1'b1;
    tick();
    req_on(12'h005, 0);
    tick();
    checks++; if (bus.ack_o !== 1'b1) begin errors++; $display("FAIL rst_ack pre: got %b expected 1", bus.ack_o); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack drop: got %b expected 0", bus.ack_o); end
    checks++; if (fcnt !== '0) begin errors++; $display("FAIL rst_ack cnt: got %0d expected 0", fcnt); end
    checks++; if (bus.dat_o !== '0) begin errors++; $display("FAIL rst_ack dat: got %h expected 0", bus.dat_o); end
    req_off();
    @(negedge clk); rst_n = 1'b1;
    tick();
    fetch(12'h005, $urandom_range(0, 3), "post_reset");
  endtask

  task automatic test_random();
    int r;
    logic [ADDR_W-1:0] adr;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        mode = ~mode;
        slen = LEN_W'($urandom_range(0, DEPTH));
      end else if (r == 1) begin
        do_start();
      end else if (r == 2) begin
        load($urandom_range(0, DEPTH - 1), DATA_W'($urandom));
      end
      if ($urandom_range(0, 3) == 0) adr = ADDR_W'($urandom);
      else adr = ADDR_W'($urandom_range(0, DEPTH - 1));
      fetch(adr, $urandom_range(0, 3), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_addressed();
    test_abort();
    test_stream();
    test_start_coincident();
    test_rbw();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_bus_stim.md
Name: inst_bus_stim

Overview:
Parametrised instruction-bus responder that stands in for the Gumnut instruction memory in core-level benches and bring-up builds. It holds a loadable instruction script and serves the inst_cyc/inst_stb/inst_ack/inst_adr/inst_dat bus with a registered, programmable-latency ack. In addressed mode it acts as a ROM indexed by address. In stream mode it returns script entries in order regardless of address, which allows directed instruction sequences without a memory image. It also counts completed fetches and flags script exhaustion.

Parameters:
ADDR_W, 12, instruction address width (matches inst_adr_o)
DATA_W, 18, instruction word width
DEPTH, 64, script entries (power of two); PTR_W = $clog2(DEPTH)
WAIT_W, 2, width of wait-state setting
FILL_INST, 18'h00000, word returned for out-of-range or exhausted accesses
CNT_W, 16, fetch counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
cyc_i  in  1  bus cycle from core
stb_i  in  1  strobe from core
adr_i  in  ADDR_W  fetch address
ack_o  out  1  registered acknowledge
dat_o  out  DATA_W  instruction word, valid while ack_o=1
mode_i  in  1  0 = addressed, 1 = stream
wait_i  in  WAIT_W  extra wait cycles before ack (0..2^WAIT_W-1)
stream_len_i  in  PTR_W+1  number of valid stream entries (0..DEPTH)
start_i  in  1  synchronous pulse: clears stream pointer and fetch counter
ld_we_i  in  1  script write enable
ld_adr_i  in  PTR_W  script write index
ld_dat_i  in  DATA_W  script write data
fetch_cnt_o  out  CNT_W  completed (acked) fetches since reset/start
done_o  out  1  mode_i=1 and ptr >= stream_len_i

Behaviour:
- Reset (rst_i=0, async): state=IDLE, ack_o=0, dat_o=0, ptr=0, wcnt=0, fetch_cnt_o=0. Script RAM is not reset. done_o is combinational and equals (mode_i && stream_len_i==0) during reset.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If cyc_i&stb_i and wait_i==0, go to ACK. Latency is 1 cycle from request.
  - If cyc_i&stb_i and wait_i!=0, load wcnt=wait_i and go to WAIT. wait_i is sampled only here.
- WAIT:
  - wcnt decrements each cycle; at wcnt==1, go to ACK. Total latency = wait_i+1 cycles.
  - If cyc_i or stb_i drops in WAIT, abort to IDLE: no ack, ptr and counter unchanged.
- ACK: ack_o=1 for exactly one cycle, then IDLE. A new request seen in that next IDLE cycle starts normally, so back-to-back fetches give one ack every (wait+2) cycles.
- dat_o is registered on the edge entering ACK and holds its value until the next ACK entry.
  - Addressed mode: mem[adr_i[PTR_W-1:0]] if adr_i < DEPTH, else FILL_INST.
  - Stream mode: mem[ptr] if ptr < stream_len_i, else FILL_INST.
- ptr increments on the ACK-entry edge in stream mode only while ptr < stream_len_i; it saturates at stream_len_i and never wraps.
- fetch_cnt_o increments on each ACK-entry edge in either mode and saturates at all-ones.
- Script writes (ld_we_i) are accepted in any state. If a write and a dat_o capture address the same entry in the same cycle, the capture returns the old word (read-before-write).
- start_i clears ptr and fetch_cnt_o. If start_i coincides with an ACK-entry edge, the clear wins: dat_o still captures using the pre-clear ptr, and counter and ptr end at 0.
- mode_i and stream_len_i must be changed only in IDLE; behaviour is undefined otherwise.
- Reset asserted mid-WAIT or mid-ACK: ack_o drops immediately, and no partial fetch is counted.

Decomposition:
- Package inst_bus_stim_pkg holds:
  - the state enum {IDLE, WAIT, ACK};
  - a mode enum {MODE_ADDR, MODE_STREAM};
  - the default FILL_INST constant.
- One sub-module, inst_script_ram: DEPTH x DATA_W, one sync write port and one async read port. The top-level mux selects the ptr or adr_i index.

Test Plan:
- Addressed, wait_i=0: load mem[5]=18'h0080A, request adr 12'h005 -> ack_o on the next cycle, dat_o=18'h0080A, fetch_cnt_o=1.
- Addressed, wait_i=3, adr 12'h0FF (DEPTH=64): ack_o 4 cycles after request, dat_o=FILL_INST. Drop stb in cycle 2 of a second request -> no ack, fetch_cnt_o stays 1.
- Stream, stream_len_i=3, script {A,B,C}, six back-to-back fetches with varied adr_i -> dat_o=A,B,C,FILL,FILL,FILL. done_o rises after the third ack; ptr stays at 3.
- start_i pulsed coincident with an ack in stream mode -> dat_o shows the current entry, then ptr=0 and fetch_cnt_o=0, and the next fetch returns A.
- Same-cycle ld_we_i to mem[ptr] with new data D' during ACK entry -> dat_o returns the old word; a refetch after start_i returns D'.
- rst_i low during WAIT -> ack_o=0 at once, all counters 0. After release, a fresh fetch completes normally.
